// File: rtl/serial_add_sub_pkg.sv
// Shared types for the bit-serial adder/subtractor: FSM states and mode encodings.
package add_sub_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;
endpackage

// File: rtl/serial_add_sub_if.sv
// Request/result bundle for serial_add_sub. dout_ovf exists only with SERIAL_ADD_SUB_OVF_EN.
interface serial_add_sub_if #(parameter int WIDTH = 8);
  logic             din_start;
  logic [WIDTH-1:0] din_A;
  logic [WIDTH-1:0] din_B;
  logic             din_cin;
  logic             din_sub;
  logic [WIDTH-1:0] dout_sum;
  logic             dout_carry;
  logic             dout_busy;
  logic             dout_done;
`ifdef SERIAL_ADD_SUB_OVF_EN
  logic             dout_ovf;
`endif

  modport master (
    output din_start, din_A, din_B, din_cin, din_sub,
    input  dout_sum, dout_carry, dout_busy, dout_done
`ifdef SERIAL_ADD_SUB_OVF_EN
    , input dout_ovf
`endif
  );

  modport slave (
    input  din_start, din_A, din_B, din_cin, din_sub,
    output dout_sum, dout_carry, dout_busy, dout_done
`ifdef SERIAL_ADD_SUB_OVF_EN
    , output dout_ovf
`endif
  );
endinterface

// File: rtl/serial_add_sub_fa_cell.sv
// Single-bit full adder shared by every bit cycle of the serial datapath.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial add/subtract, one bit per clock LSB first, WIDTH cycles per operation.
// Optional signed-overflow output enabled by defining SERIAL_ADD_SUB_OVF_EN.
module serial_add_sub
  import add_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  serial_add_sub_if.slave bus
);
  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           st, st_nxt;
  logic             accept, last_bit;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr, b_sr, sum_sr, sum_q;
  logic             sub_q, carry, carry_q;
  logic             fa_b, fa_s, fa_cout;

  // Subtraction reuses the adder: B is inverted bit by bit as it shifts out.
  assign fa_b = (sub_q == MODE_ADD) ? b_sr[0] : ~b_sr[0];

  fa_cell u_fa (
    .a    (a_sr[0]),
    .b    (fa_b),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_cout)
  );

  always_comb begin
    st_nxt   = st;
    accept   = 1'b0;
    last_bit = (st == RUN) && (cnt == LAST);
    case (st)
      IDLE: if (bus.din_start) begin
        accept = 1'b1;
        st_nxt = RUN;
      end
      RUN:  if (last_bit) st_nxt = DONE;
      DONE: begin
        if (bus.din_start) begin
          accept = 1'b1;
          st_nxt = RUN;
        end else begin
          st_nxt = IDLE;
        end
      end
      default: st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) st <= IDLE;
    else        st <= st_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      a_sr    <= '0;
      b_sr    <= '0;
      sum_sr  <= '0;
      sum_q   <= '0;
      sub_q   <= MODE_ADD;
      carry   <= 1'b0;
      carry_q <= 1'b0;
    end else if (accept) begin
      cnt   <= '0;
      a_sr  <= bus.din_A;
      b_sr  <= bus.din_B;
      sub_q <= bus.din_sub;
      // Borrow-in maps to an inverted carry-in for two's-complement subtract.
      carry <= (bus.din_sub == MODE_SUB) ? ~bus.din_cin : bus.din_cin;
    end else if (st == RUN) begin
      cnt    <= cnt + 1'b1;
      a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
      sum_sr <= {fa_s, sum_sr[WIDTH-1:1]};
      carry  <= fa_cout;
      if (last_bit) begin
        sum_q   <= {fa_s, sum_sr[WIDTH-1:1]};
        carry_q <= fa_cout;
      end
    end
  end

`ifdef SERIAL_ADD_SUB_OVF_EN
  logic ovf_q;

  // On the MSB cycle, the carry register holds the carry into the MSB.
  always_ff @(posedge clk) begin
    if (!rst_n)                         ovf_q <= 1'b0;
    else if (!accept && last_bit)       ovf_q <= carry ^ fa_cout;
  end

  assign bus.dout_ovf = ovf_q;
`endif

  assign bus.dout_sum   = sum_q;
  assign bus.dout_carry = carry_q;
  assign bus.dout_busy  = (st == RUN);
  assign bus.dout_done  = (st == DONE);
endmodule

// File: tb/tb_serial_add_sub.sv
// Self-checking bench for serial_add_sub (WIDTH=8): vector table, scoreboard, corner sequences.
module tb_serial_add_sub;
  import add_sub_pkg::*;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] sum;
    logic         carry;
    logic         ovf;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_add_sub_if #(.WIDTH(W)) bus ();

  serial_add_sub #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int           n_tests = 0;
  int           n_fail  = 0;
  vec_t         sb[$];
  vec_t         tbl[10];
  logic [W-1:0] prev_sum = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference from plain integer arithmetic: carry = no borrow for subtract.
  function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic cin, input logic sub);
    vec_t v;
    int   r, s, ia, ib, sa, sb_;
    ia  = int'(a);
    ib  = int'(b);
    sa  = int'($signed(a));
    sb_ = int'($signed(b));
    v.a = a; v.b = b; v.cin = cin; v.sub = sub;
    if (sub == MODE_ADD) begin
      r       = ia + ib + int'(cin);
      v.carry = (r >= (1 << W));
      s       = sa + sb_ + int'(cin);
    end else begin
      r       = ia - ib - int'(cin);
      v.carry = (ia >= ib + int'(cin));
      s       = sa - sb_ - int'(cin);
    end
    v.sum = r[W-1:0];
    v.ovf = (s > 127) || (s < -128);
    return v;
  endfunction

  always @(negedge clk) begin
    vec_t e;
    if (rst_n === 1'b1 && bus.dout_done === 1'b1) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 want no pending op (t=%0t)", $time);
      end else begin
        e = sb.pop_front();
        chk("sum", 64'(bus.dout_sum), 64'(e.sum));
        chk("carry", 64'(bus.dout_carry), 64'(e.carry));
`ifdef SERIAL_ADD_SUB_OVF_EN
        chk("ovf", 64'(bus.dout_ovf), 64'(e.ovf));
`endif
        prev_sum = e.sum;
      end
    end
  end

  task automatic drive(input vec_t v, input logic start);
    bus.din_A     = v.a;
    bus.din_B     = v.b;
    bus.din_cin   = v.cin;
    bus.din_sub   = v.sub;
    bus.din_start = start;
  endtask

  // One operation from IDLE; inputs are scrambled during RUN, optional start glitch.
  // Edge counting treats the accepting edge as edge 1.
  task automatic run_op(input vec_t v, input int glitch);
    int edges, busy_n;
    bit seen;
    drive(v, 1'b1);
    sb.push_back(v);
    @(posedge clk); #1;
    edges  = 1;
    busy_n = 0;
    seen   = 0;
    while (!seen && edges <= 3 * W) begin
      if (bus.dout_done === 1'b1) begin
        seen = 1;
      end else begin
        if (bus.dout_busy === 1'b1) begin
          busy_n++;
          chk("hold_sum", 64'(bus.dout_sum), 64'(prev_sum));
        end
        bus.din_A     = W'($urandom);
        bus.din_B     = W'($urandom);
        bus.din_cin   = 1'($urandom);
        bus.din_sub   = 1'($urandom);
        bus.din_start = (busy_n == glitch);
        if (busy_n == glitch) begin
          bus.din_A = 8'hAA;
          bus.din_B = 8'h55;
        end
        @(posedge clk); #1;
        edges++;
      end
    end
    bus.din_start = 1'b0;
    chk("done_seen", 64'(seen), 64'd1);
    chk("latency", 64'(edges), 64'(W + 1));
    chk("busy_cycles", 64'(busy_n), 64'(W));
    @(posedge clk); #1;
    chk("done_one_cycle", 64'(bus.dout_done), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_sum"}, 64'(bus.dout_sum), 64'd0);
    chk({tag, "_carry"}, 64'(bus.dout_carry), 64'd0);
    chk({tag, "_busy"}, 64'(bus.dout_busy), 64'd0);
    chk({tag, "_done"}, 64'(bus.dout_done), 64'd0);
`ifdef SERIAL_ADD_SUB_OVF_EN
    chk({tag, "_ovf"}, 64'(bus.dout_ovf), 64'd0);
`endif
  endtask

  task automatic abort_run();
    int dn;
    drive(mk(8'h33, 8'h44, 1'b0, MODE_ADD), 1'b1);
    @(posedge clk); #1;
    bus.din_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_busy_before", 64'(bus.dout_busy), 64'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("abort");
    prev_sum = '0;
    rst_n    = 1'b1;
    dn       = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.dout_done === 1'b1) dn++;
    end
    chk("abort_no_done", 64'(dn), 64'd0);
  endtask

  task automatic back_to_back(input int n);
    int e;
    for (int k = 0; k < n; k++) begin
      drive(tbl[k], 1'b1);
      sb.push_back(tbl[k]);
      @(posedge clk); #1;
      e = 1;
      while (bus.dout_done !== 1'b1 && e <= 3 * W) begin
        @(posedge clk); #1;
        e++;
      end
      chk("b2b_period", 64'(e), 64'(W + 1));
    end
    bus.din_start = 1'b0;
    @(posedge clk); #1;
    chk("b2b_idle_busy", 64'(bus.dout_busy), 64'd0);
  endtask

  initial begin
    tbl[0] = '{8'hFF, 8'h01, 1'b0, MODE_ADD, 8'h00, 1'b1, 1'b0};
    tbl[1] = '{8'h05, 8'h07, 1'b0, MODE_SUB, 8'hFE, 1'b0, 1'b0};
    tbl[2] = '{8'h7F, 8'h01, 1'b0, MODE_ADD, 8'h80, 1'b0, 1'b1};
    tbl[3] = '{8'h10, 8'h20, 1'b0, MODE_ADD, 8'h30, 1'b0, 1'b0};
    tbl[4] = '{8'h01, 8'h01, 1'b0, MODE_ADD, 8'h02, 1'b0, 1'b0};
    tbl[5] = mk(8'h80, 8'h01, 1'b0, MODE_SUB);
    tbl[6] = mk(8'h00, 8'h00, 1'b1, MODE_SUB);
    tbl[7] = mk(8'hFF, 8'hFF, 1'b1, MODE_ADD);
    tbl[8] = mk(8'hA5, 8'h3C, 1'b1, MODE_SUB);
    tbl[9] = mk(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));

    drive(tbl[0], 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_op(tbl[i], -1);

    // Start pulse in the third RUN cycle must not disturb 0x10+0x20.
    run_op(tbl[3], 3);

    abort_run();
    run_op(tbl[4], -1);

    // Reset wins over a simultaneous start.
    drive(tbl[7], 1'b1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_prio_busy", 64'(bus.dout_busy), 64'd0);
    rst_n         = 1'b1;
    bus.din_start = 1'b0;
    prev_sum      = '0;
    @(posedge clk); #1;
    chk("rst_prio_idle", 64'(bus.dout_busy), 64'd0);

    back_to_back(5);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/serial_add_sub.md
SERIAL_ADD_SUB -- requirements
Module: serial_add_sub

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; SHALL be legal for 2..64.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 din_start  input  1  request; accepted only in IDLE or DONE.
REQ-005 din_A  input  WIDTH  operand A, sampled on the accepting edge.
REQ-006 din_B  input  WIDTH  operand B, sampled on the accepting edge.
REQ-007 din_cin  input  1  carry-in (add) / borrow-in (sub), sampled on the accepting edge.
REQ-008 din_sub  input  1  mode, sampled on the accepting edge: 0 = add, 1 = subtract.
REQ-009 dout_sum  output  WIDTH  result register.
REQ-010 dout_carry  output  1  final carry-out; in subtract mode 1 = no borrow.
REQ-011 dout_busy  output  1  high while in RUN.
REQ-012 dout_done  output  1  one-cycle pulse; result valid.
REQ-013 dout_ovf  output  1  signed overflow; present only when SERIAL_ADD_SUB_OVF_EN is defined.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-015 IDLE: din_start=1 -> capture operands and mode, clear bit counter, go to RUN; otherwise stay in IDLE.
REQ-016 RUN: process one bit per cycle, LSB first, via the full-adder cell; after bit WIDTH-1 go to DONE.
REQ-017 DONE lasts exactly one cycle; dout_done=1 only in DONE.
REQ-018 DONE + din_start=1 -> capture new operands and go to RUN; otherwise go to IDLE.
REQ-019 Latency: dout_done SHALL rise exactly WIDTH+1 rising edges after the edge that accepted din_start.
REQ-020 dout_busy SHALL be high for exactly WIDTH cycles per operation.
REQ-021 Add: result = A + B + din_cin, initial carry = din_cin.
REQ-022 Subtract: B bits inverted, initial carry = ~din_cin; result = A - B - din_cin.
REQ-023 dout_sum and dout_carry SHALL update only on entry to DONE.
REQ-024 dout_sum and dout_carry SHALL hold their values until the next DONE or reset.
REQ-025 din_start while in RUN SHALL be ignored, with no effect on the operation in flight.
REQ-026 Input changes after the accepting edge SHALL NOT affect the operation in flight.
REQ-027 The bit counter SHALL be $clog2(WIDTH) bits wide; terminal count is WIDTH-1.

Reset
REQ-028 rst_n=0 at any rising edge -> state IDLE, counter 0, dout_sum 0, dout_carry 0, dout_busy 0, dout_done 0, dout_ovf 0.
REQ-029 Reset during RUN SHALL abort the operation with no dout_done pulse.
REQ-030 Reset SHALL take priority over a simultaneous din_start.

Configuration
REQ-031 Macro SERIAL_ADD_SUB_OVF_EN defined: dout_ovf = (carry into MSB) XOR (carry out of MSB).
REQ-032 dout_ovf SHALL be updated and held under the same rules as dout_sum (REQ-023/024).
REQ-033 Macro undefined: the dout_ovf port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-034 Shared package add_sub_pkg SHALL hold the FSM state typedef (IDLE/RUN/DONE) and the mode constants MODE_ADD=0 and MODE_SUB=1.
REQ-035 The single-bit adder SHALL be sub-module fa_cell (inputs a, b, cin; outputs s, cout), instantiated once.
REQ-036 The carry SHALL be a 1-bit register between bit cycles.
REQ-037 Operand and result storage SHALL be shift registers.

Verification (WIDTH=8)
REQ-038 Add 0xFF + 0x01, cin=0 -> sum 0x00, carry 1, done exactly 9 edges after start.
REQ-039 Sub 0x05 - 0x07, cin=0 -> sum 0xFE, carry 0 (borrow); ovf 0 when OVF_EN defined.
REQ-040 Add 0x7F + 0x01, cin=0 -> sum 0x80, carry 0; ovf 1 when OVF_EN defined.
REQ-041 Start 0x10+0x20; pulse start with 0xAA+0x55 at cycle 3 -> ignored, result 0x30, busy high exactly 8 cycles.
REQ-042 rst_n low at cycle 4 of RUN -> no done pulse, all outputs 0; next start 0x01+0x01 -> sum 0x02.
REQ-043 Start held high continuously -> back-to-back operations, done pulses every 9 cycles, each with a correct result.
